// File: rtl/imm_pkg.sv
// Shared constants for the 10-bit immediate path. The sign-extension side uses
// the same widths, saturation codes and mode encoding.
package imm_pkg;

    localparam int unsigned IMM_IN_W  = 16;
    localparam int unsigned IMM_OUT_W = 10;

    // Largest positive and most negative 10-bit signed immediates.
    localparam logic [IMM_OUT_W-1:0] SAT_POS = 10'h1FF;
    localparam logic [IMM_OUT_W-1:0] SAT_NEG = 10'h200;

    // Narrowing mode, sampled together with the data word.
    typedef enum logic {
        MODE_TRUNC = 1'b0,
        MODE_SAT   = 1'b1
    } imm_mode_e;

endpackage

// File: rtl/pipe_stage_vr.sv
// One elastic valid/ready register stage.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_data               payload captured on an upstream handshake
//   out_valid/out_ready   downstream handshake
//   out_data              registered payload, stable while out_valid && !out_ready
module pipe_stage_vr #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             valid_q;
    logic [Width-1:0] data_q;
    logic             load;

    // Loadable when empty or when the current contents leave this cycle.
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (in_ready) begin
                valid_q <= in_valid;
            end
            if (load) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/imm_narrow_16to10.sv
// Registered 16-to-10-bit signed narrowing unit with a two-stage elastic
// pipeline and a saturating count of delivered non-fitting results.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational on out_ready)
//   data_in, mode         16-bit signed value; mode 0 = wrap, 1 = saturate
//   out_valid/out_ready   downstream handshake
//   data_out, fits        narrowed value and representability flag (registered)
//   ovf_count, clr_count  overflow counter and its synchronous clear
module imm_narrow_16to10
    import imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             fits,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    // Stage 1: raw value plus mode.
    logic            s1_valid;
    logic            s1_ready;
    logic [IN_W:0]   s1_data;
    logic [IN_W-1:0] s1_value;
    logic            s1_mode;

    // Stage 2: {fits, narrowed value}.
    logic            s2_ready;
    logic [OUT_W:0]  s2_in;
    logic [OUT_W:0]  s2_data;

    logic             s1_fits;
    logic             s1_sign;
    logic [OUT_W-1:0] s1_narrow;

    pipe_stage_vr #(
        .Width (IN_W + 1)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s1_ready),
        .in_data   ({mode, data_in}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign in_ready = s1_ready;
    assign s1_value = s1_data[IN_W-1:0];
    assign s1_mode  = s1_data[IN_W];

    // Representable iff the discarded bits all match the new sign bit.
    assign s1_fits = (&s1_value[IN_W-1:OUT_W-1]) | ~(|s1_value[IN_W-1:OUT_W-1]);
    assign s1_sign = s1_value[IN_W-1];

    always_comb begin
        s1_narrow = s1_value[OUT_W-1:0];
        if (!s1_fits && (s1_mode == MODE_SAT)) begin
            s1_narrow = s1_sign ? SAT_NEG : SAT_POS;
        end
    end

    assign s2_in = {s1_fits, s1_narrow};

    pipe_stage_vr #(
        .Width (OUT_W + 1)
    ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign data_out = s2_data[OUT_W-1:0];
    assign fits     = s2_data[OUT_W];

    // Overflow counter: clear wins over a same-cycle increment.
    logic [CNT_W-1:0] ovf_count_q;
    logic [CNT_W-1:0] ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_count) begin
            ovf_count_d = '0;
        end else if (out_valid && out_ready && !fits && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_imm_narrow_16to10.sv
module tb_imm_narrow_16to10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  data_out;
    logic        fits;
    logic [7:0]  ovf_count;
    logic        clr_count;

    imm_narrow_16to10 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .fits      (fits),
        .ovf_count (ovf_count),
        .clr_count (clr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] din;
        logic        md;
        logic [9:0]  dout;
        logic        ft;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          exp_ovf;
        int          sent;
        int          gaps;
        int          hs;
        logic [9:0]  rx[$];

        vecs[0] = '{16'h00FF, 1'b1, 10'h0FF, 1'b1};
        vecs[1] = '{16'hFE00, 1'b1, 10'h200, 1'b1};
        vecs[2] = '{16'h01FF, 1'b1, 10'h1FF, 1'b1};
        vecs[3] = '{16'h0200, 1'b1, 10'h1FF, 1'b0};
        vecs[4] = '{16'h8000, 1'b1, 10'h200, 1'b0};
        vecs[5] = '{16'h0200, 1'b0, 10'h200, 1'b0};
        vecs[6] = '{16'h7C15, 1'b0, 10'h015, 1'b0};
        vecs[7] = '{16'hFFFF, 1'b0, 10'h3FF, 1'b1};
        vecs[8] = '{16'hFDFF, 1'b1, 10'h200, 1'b0};
        vecs[9] = '{16'hFDFF, 1'b0, 10'h1FF, 1'b0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        clr_count = 1'b0;
        cyc();
        cyc();
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_fits", fits, 0);
        check("rst_ovf", ovf_count, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;

        // Table-driven single beats, unloaded pipeline.
        exp_ovf = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            data_in   = vecs[i].din;
            mode      = vecs[i].md;
            out_ready = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            cyc();
            in_valid = 1'b0;
            data_in  = '0;
            check($sformatf("v%0d_lat_early", i), out_valid, 0);
            cyc();
            check($sformatf("v%0d_out_valid", i), out_valid, 1);
            check($sformatf("v%0d_data_out", i), data_out, vecs[i].dout);
            check($sformatf("v%0d_fits", i), fits, vecs[i].ft);
            if (!vecs[i].ft) exp_ovf++;
            cyc();
            check($sformatf("v%0d_ovf", i), ovf_count, exp_ovf);
            check($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Backpressure: 4 cycles stalled, then release.
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            data_in  = 16'(sent + 1);
            mode     = 1'b0;
            #1;
            if (in_ready) sent++;
            cyc();
        end
        check("bp_accepts", sent, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_data", data_out, 10'h001);
        out_ready = 1'b1;
        gaps = 0;
        for (int c = 0; c < 30 && rx.size() < 5; c++) begin
            in_valid = (sent < 5);
            data_in  = 16'(sent + 1);
            #1;
            if (out_valid) rx.push_back(data_out);
            else gaps++;
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid = 1'b0;
        check("bp_rx_count", rx.size(), 5);
        check("bp_gaps", gaps, 0);
        for (int i = 0; i < rx.size(); i++) begin
            check($sformatf("bp_rx%0d", i), rx[i], i + 1);
        end
        cyc();
        cyc();

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 16'h8000;
        mode      = 1'b1;
        cyc();
        data_in = 16'h0200;
        cyc();
        in_valid = 1'b0;
        check("mr_full_valid", out_valid, 1);
        check("mr_full_ready", in_ready, 0);
        check("mr_ovf_nonzero", ovf_count, exp_ovf);
        #2;
        rst = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_data_out", data_out, 0);
        check("mr_fits", fits, 0);
        check("mr_ovf", ovf_count, 0);
        check("mr_in_ready", in_ready, 1);
        cyc();
        rst       = 1'b1;
        in_valid  = 1'b1;
        data_in   = 16'h0003;
        mode      = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mr_first_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("mr_first_valid", out_valid, 1);
        check("mr_first_data", data_out, 10'h003);
        check("mr_first_fits", fits, 1);
        cyc();

        // Counter saturation with a full-rate stream.
        in_valid  = 1'b1;
        data_in   = 16'h0200;
        mode      = 1'b1;
        out_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 400 && hs < 300; i++) begin
            #1;
            if (out_valid && out_ready && !fits) hs++;
            cyc();
        end
        in_valid = 1'b0;
        check("cnt_handshakes", hs, 300);
        cyc();
        cyc();
        cyc();
        check("cnt_saturated", ovf_count, 8'd255);

        // Clear concurrent with a non-fitting handshake.
        in_valid = 1'b1;
        data_in  = 16'h8000;
        mode     = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("clr_pre_valid", out_valid, 1);
        clr_count = 1'b1;
        cyc();
        clr_count = 1'b0;
        check("clr_result", ovf_count, 0);

        in_valid = 1'b1;
        data_in  = 16'h0400;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("cnt_after_clr", ovf_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
